// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin subtractor, LSB first, one bit per clock.
// Start/busy/done handshake; result delivered in parallel and as a serial stream.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             diff_bit,
    output logic             diff_bit_valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits received so far; the final bit joins them on the last edge.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_cat;
    logic             brw;
    logic             brw_next;
    logic             d;
    logic             last;
    logic [CW-1:0]    cnt;

    assign d        = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign res_cat  = {d, res_sr};
    assign last     = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr           <= '0;
            b_sr           <= '0;
            res_sr         <= '0;
            brw            <= 1'b0;
            cnt            <= '0;
            diff           <= '0;
            bout           <= 1'b0;
            diff_bit       <= 1'b0;
            diff_bit_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr           <= a_sr >> 1;
                    b_sr           <= b_sr >> 1;
                    brw            <= brw_next;
                    res_sr         <= res_cat[WIDTH-1:1];
                    diff_bit       <= d;
                    diff_bit_valid <= 1'b1;
                    cnt            <= cnt + 1'b1;
                    if (last) begin
                        diff <= res_cat;
                        bout <= brw_next;
                    end
                end
                DONE: begin
                    // The last serial bit stays qualified through the done cycle.
                    diff_bit_valid <= 1'b0;
                end
                default: begin
                    diff_bit_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit handshake/serial/reset cases and
// an exhaustive 4-bit sweep checked against a subtract model and an adder cross-check.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start8 = 1'b0;
    logic [W-1:0]  a8 = '0, b8 = '0;
    logic          bin8 = 1'b0;
    logic          busy8, done8, bout8, dbit8, dval8;
    logic [W-1:0]  diff8;

    logic          start4 = 1'b0;
    logic [W4-1:0] a4 = '0, b4 = '0;
    logic          bin4 = 1'b0;
    logic          busy4, done4, bout4, dbit4, dval4;
    logic [W4-1:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
        .diff_bit(dbit8), .diff_bit_valid(dval8)
    );

    serial_subtractor #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4),
        .diff_bit(dbit4), .diff_bit_valid(dval4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 8-bit operation with cycle-accurate checks; optional start pulse during RUN.
    task automatic op8(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic binv, input logic [W-1:0] exp_diff, input logic exp_bout,
                       input bit glitch);
        a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
        tick();                                   // accepting edge k
        start8 = 1'b0;
        check({tag, "_busy_accept"}, 32'(busy8), 32'd1);
        for (int i = 0; i < W; i++) begin
            if (glitch && i == 2) begin
                a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
            end
            if (glitch && i == 3) start8 = 1'b0;
            tick();                               // edge k+1+i
            check($sformatf("%s_bit%0d", tag, i), 32'({dval8, dbit8}), 32'({1'b1, exp_diff[i]}));
            if (i < W - 1) check($sformatf("%s_nodone%0d", tag, i), 32'(done8), 32'd0);
        end
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_diff"}, 32'(diff8), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bout8), 32'(exp_bout));
        tick();
        check({tag, "_idle"}, 32'({busy8, done8, dval8}), 32'd0);
        check({tag, "_hold"}, 32'({bout8, diff8}), 32'({exp_bout, exp_diff}));
        $display("op %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d", tag, av, bv, binv, diff8, bout8);
    endtask

    initial begin
        int done_cyc[3];
        int ndone;
        int cyc;
        logic [W4:0] model;
        logic [W4:0] xsum;
        bit got;

        #2;
        check("reset_outputs", 32'({busy8, done8, dval8, dbit8, bout8, diff8}), 32'd0);
        check("reset_outputs4", 32'({busy4, done4, dval4, dbit4, bout4, diff4}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Case 1: 0x5A - 0x3C = 0x1E, serial 0,1,1,1,1,0,0,0
        op8("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        // Case 2: borrow boundaries
        op8("zero_minus_one", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("equal_with_bin", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0);
        op8("max_minus_zero", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
        // Case 3: start during RUN ignored
        op8("start_in_run", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no_extra_op%0d", i), 32'({busy8, done8}), 32'd0);
        end

        // Case 4: start held high, three back-to-back operations
        a8 = 8'hC3; b8 = 8'h4D; bin8 = 1'b1; start8 = 1'b1;
        ndone = 0;
        cyc = 0;
        while (ndone < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done8) begin
                done_cyc[ndone] = cyc;
                check($sformatf("b2b_diff%0d", ndone), 32'({bout8, diff8}), 32'({1'b0, 8'h75}));
                ndone++;
                if (ndone == 3) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check("b2b_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            check("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'(W + 2));
            check("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'(W + 2));
        end
        $display("op back_to_back: 3x C3-4D-1 done at cycles %0d %0d %0d", done_cyc[0], done_cyc[1], done_cyc[2]);
        tick();
        tick();
        check("b2b_stopped", 32'(busy8), 32'd0);

        // Case 5: reset after the 4th RUN edge
        a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_reset_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'({busy8, done8, dval8, bout8, diff8}), 32'd0);
        tick();
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done8 || busy8) got = 1'b1;
        end
        check("rst_no_done", 32'(got), 32'd0);
        $display("op reset_abort: a=12 b=34 aborted");
        op8("after_reset", 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);

        // Case 6: exhaustive 4-bit sweep
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    got = 1'b0;
                    for (int t = 0; t < W4 + 3 && !got; t++) begin
                        tick();
                        if (done4) got = 1'b1;
                    end
                    model = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
                    xsum  = {1'b0, a4} + {1'b0, ~b4} + {4'b0, ~bin4};
                    if (!got) begin
                        check($sformatf("w4_timeout_%0d_%0d_%0d", ai, bi, ci), 32'd0, 32'd1);
                    end else begin
                        check($sformatf("w4_model_%0d_%0d_%0d", ai, bi, ci),
                              32'({bout4, diff4}), 32'(model));
                        check($sformatf("w4_adder_%0d_%0d_%0d", ai, bi, ci),
                              32'({bout4, diff4}), 32'({~xsum[W4], xsum[W4-1:0]}));
                    end
                    tick();
                end
            end
        end
        $display("op w4_sweep: 512 operations completed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
